// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch path: PC type, sequencer
// states, redirect sources ordered by priority, and default vectors.
package mips_fetch_pkg;

    typedef logic [31:0] pc_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pcseq_state_e;

    // Encoding order doubles as priority: a larger code wins.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_JMP  = 2'd2,
        SRC_EXC  = 2'd3
    } redir_src_e;

    localparam pc_t DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam pc_t DEFAULT_EXC_VECTOR   = 32'h0000_0080;

    function automatic logic is_misaligned(input pc_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/redirect_arb.sv
// Combinational redirect arbiter: picks exc > jump > branch and replaces a
// misaligned jump/branch target with the exception vector.
module redirect_arb
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic        enable,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    output logic [31:0] target,
    output redir_src_e  src,
    output logic        misalign
);

    always_comb begin
        target   = EXC_VECTOR;
        src      = SRC_NONE;
        misalign = 1'b0;
        if (enable) begin
            if (exc_req) begin
                src = SRC_EXC;
            end else if (jump) begin
                src = SRC_JMP;
                if (is_misaligned(jump_target)) begin
                    misalign = 1'b1;
                end else begin
                    target = jump_target;
                end
            end else if (br_taken) begin
                src = SRC_BR;
                if (is_misaligned(br_target)) begin
                    misalign = 1'b1;
                end else begin
                    target = br_target;
                end
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter owner: sequential/redirect PC selection, stall
// hold, and a one-entry pending buffer for redirects that arrive mid-stall.
module pc_sequencer
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_next,
    input  logic        imem_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    output logic [31:0] in_pc,
    output logic        fetch_valid,
    output logic        redirect_ack,
    output logic        misalign_err
);

    pcseq_state_e state_q, state_d;
    pc_t          pc_d;
    logic         ack_d;
    logic         misalign_set;

    // Pending buffer; the source code doubles as the valid bit (SRC_NONE = empty).
    pc_t          pend_target, pend_target_d;
    redir_src_e   pend_src, pend_src_d;

    logic [31:0]  arb_target;
    redir_src_e   arb_src;
    logic         arb_misalign;

    logic         redir;
    logic         take_hold;
    pc_t          hold_target;
    redir_src_e   hold_src;

    redirect_arb #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_arb (
        .enable      (state_q != BOOT),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .exc_req     (exc_req),
        .target      (arb_target),
        .src         (arb_src),
        .misalign    (arb_misalign)
    );

    assign redir       = (arb_src != SRC_NONE);
    // Equal priority replaces, so the most recent request of a class wins.
    assign take_hold   = redir && (arb_src >= pend_src);
    assign hold_target = take_hold ? arb_target : pend_target;
    assign hold_src    = take_hold ? arb_src    : pend_src;

    always_comb begin
        state_d       = state_q;
        pc_d          = in_pc;
        ack_d         = 1'b0;
        pend_target_d = pend_target;
        pend_src_d    = pend_src;
        misalign_set  = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redir) begin
                    misalign_set = arb_misalign;
                    if (imem_ready) begin
                        pc_d  = arb_target;
                        ack_d = 1'b1;
                    end else begin
                        pend_target_d = arb_target;
                        pend_src_d    = arb_src;
                        state_d       = HOLD;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_next;
                end
            end
            HOLD: begin
                if (take_hold) begin
                    misalign_set = arb_misalign;
                end
                if (imem_ready) begin
                    pc_d       = hold_target;
                    ack_d      = 1'b1;
                    pend_src_d = SRC_NONE;
                    state_d    = RUN;
                end else begin
                    pend_target_d = hold_target;
                    pend_src_d    = hold_src;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            in_pc        <= RESET_VECTOR;
            fetch_valid  <= 1'b0;
            redirect_ack <= 1'b0;
            misalign_err <= 1'b0;
            pend_src     <= SRC_NONE;
        end else begin
            state_q      <= state_d;
            in_pc        <= pc_d;
            fetch_valid  <= (state_d != BOOT);
            redirect_ack <= ack_d;
            misalign_err <= misalign_err | misalign_set;
            pend_src     <= pend_src_d;
        end
    end

    // Target storage is qualified by pend_src, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_target <= pend_target_d;
    end

endmodule
